// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM encoding and default sizing.
package prog_loader_pkg;

    localparam int DEF_WORD_W    = 8;
    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_CLEAR_VAL = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLEAR   = 2'd1,
        ST_LOAD    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

endpackage

// File: rtl/prog_loader.sv
// Program loader: optionally fills the external memory with a clear value,
// then streams len words into addresses 0..len-1 and releases the processor
// from reset once the whole image is in place.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int                WORD_W    = DEF_WORD_W,
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter logic [WORD_W-1:0] CLEAR_VAL = WORD_W'(DEF_CLEAR_VAL)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clear_en,
    input  logic [ADDR_W:0]   len,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    state_t            state_reg, state_next;
    logic [ADDR_W:0]   len_reg;
    logic [ADDR_W:0]   count_reg;
    logic [ADDR_W:0]   count_inc;
    logic [ADDR_W-1:0] clr_addr_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [WORD_W-1:0] mem_wdata_reg;
    logic              cpu_rst_reg;
    logic              err_reg;

    logic len_ok;
    logic start_ok;
    logic start_bad;
    logic load_rdy;
    logic xfer;
    logic clr_last;
    logic working;

    // len is one bit wider than an address, so it exceeds DEPTH exactly when
    // the top bit is set together with any lower bit.
    assign len_ok    = !(len[ADDR_W] && (|len[ADDR_W-1:0]));
    assign start_ok  = (state_reg == ST_IDLE) && start && len_ok;
    assign start_bad = (state_reg == ST_IDLE) && start && !len_ok;
    assign load_rdy  = (state_reg == ST_LOAD) && (count_reg != len_reg);
    // abort wins over a word offered in the same cycle
    assign xfer      = load_rdy && in_valid && !abort;
    assign count_inc = count_reg + 1'b1;
    assign clr_last  = &clr_addr_reg;
    assign working   = (state_reg == ST_CLEAR) || (state_reg == ST_LOAD);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode and state-derived outputs
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                busy = 1'b0;
                if (start_ok) begin
                    state_next = clear_en ? ST_CLEAR : ST_LOAD;
                end
            end
            ST_CLEAR: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (clr_last) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                in_ready = load_rdy;
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (count_reg == len_reg) begin
                    // only reachable with len = 0
                    state_next = ST_RELEASE;
                end else if (xfer && (count_inc == len_reg)) begin
                    state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: counters, registered write port, processor reset and error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_reg       <= '0;
            count_reg     <= '0;
            clr_addr_reg  <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            cpu_rst_reg   <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            mem_we_reg <= 1'b0;
            if (start_bad) begin
                err_reg <= 1'b1;
            end
            if (start_ok) begin
                len_reg      <= len;
                count_reg    <= '0;
                clr_addr_reg <= '0;
                err_reg      <= 1'b0;
                cpu_rst_reg  <= 1'b0;
            end
            if ((state_reg == ST_CLEAR) && !abort) begin
                mem_we_reg    <= 1'b1;
                mem_addr_reg  <= clr_addr_reg;
                mem_wdata_reg <= CLEAR_VAL;
                clr_addr_reg  <= clr_addr_reg + 1'b1;
            end
            if (xfer) begin
                mem_we_reg    <= 1'b1;
                mem_addr_reg  <= count_reg[ADDR_W-1:0];
                mem_wdata_reg <= in_data;
                count_reg     <= count_inc;
            end
            if (working && abort) begin
                err_reg <= 1'b1;
            end
            if (state_reg == ST_RELEASE) begin
                cpu_rst_reg <= 1'b1;
            end
        end
    end

    assign mem_we       = mem_we_reg;
    assign mem_addr     = mem_addr_reg;
    assign mem_wdata    = mem_wdata_reg;
    assign cpu_rst      = cpu_rst_reg;
    assign err          = err_reg;
    // count never passes len, so it doubles as the saturating word counter
    assign words_loaded = count_reg;

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter WORD_W, default 8, data word width.
REQ-002 SHALL have parameter ADDR_W, default 8, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter CLEAR_VAL, default 0, WORD_W-bit fill value for the clear pass.
REQ-004 SHALL have ports:
  clk  in  1  single clock, rising edge
  rst  in  1  asynchronous, active-low reset
  start  in  1  one-cycle load request
  clear_en  in  1  sampled at start; 1 = clear whole memory before loading
  len  in  ADDR_W+1  word count, sampled at start, legal 0..DEPTH
  abort  in  1  cancel operation in progress
  in_valid  in  1  program word offered
  in_data  in  WORD_W  program word
  in_ready  out  1  loader accepts word this cycle
  mem_we  out  1  memory write strobe
  mem_addr  out  ADDR_W  memory write address
  mem_wdata  out  WORD_W  memory write data
  cpu_rst  out  1  active-low reset to the processor
  busy  out  1  operation in progress
  done  out  1  one-cycle completion pulse
  err  out  1  sticky error flag
  words_loaded  out  ADDR_W+1  words written in last/current load

Function
REQ-005 SHALL implement FSM states IDLE, CLEAR, LOAD, RELEASE.
REQ-006 IDLE: start=1 SHALL latch clear_en and len, clear err and words_loaded, drive cpu_rst=0, go to CLEAR if clear_en else LOAD.
REQ-007 start with len > DEPTH SHALL set err, leave state IDLE, perform no writes, leave cpu_rst unchanged.
REQ-008 start while busy=1 SHALL be ignored.
REQ-009 CLEAR SHALL write CLEAR_VAL to addresses 0..DEPTH-1, one per cycle, ascending, exactly DEPTH writes, then go to LOAD.
REQ-010 LOAD SHALL drive in_ready=1 while accepted count < len; a word transfers when in_valid&&in_ready.
REQ-011 Transferred word k (k=0..len-1) SHALL be written to address k, with mem_we/mem_addr/mem_wdata registered one cycle after the transfer.
REQ-012 in_ready SHALL be 0 in every state except LOAD; in_valid outside LOAD SHALL be ignored.
REQ-013 words_loaded SHALL increment on each transfer and saturate at len.
REQ-014 After the transfer that reaches count=len (immediately if len=0), FSM SHALL go to RELEASE.
REQ-015 RELEASE SHALL last one cycle: done=1, cpu_rst driven 1 from the next cycle, then IDLE.
REQ-016 cpu_rst SHALL remain 1 in IDLE after a successful load, until the next accepted start.
REQ-017 abort=1 in CLEAR or LOAD SHALL, on the next edge, go to IDLE, set err, suppress further writes (a write already registered still completes), and keep cpu_rst=0.
REQ-018 abort in IDLE or RELEASE SHALL be ignored; abort has priority over a simultaneous transfer.
REQ-019 Address counter SHALL never wrap; len=DEPTH writes exactly addresses 0..DEPTH-1.
REQ-020 busy SHALL be 1 in CLEAR, LOAD, RELEASE.

Reset
REQ-021 rst=0 SHALL asynchronously force IDLE, cpu_rst=0, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, words_loaded=0.
REQ-022 Reset mid-CLEAR/LOAD SHALL abandon the operation with no further writes; the processor stays in reset until a completed load.

Structure
REQ-023 FSM state encoding and default parameter constants SHALL live in a shared package, prog_loader_pkg.
REQ-024 Single module; no sub-module; memory is external and driven through the mem_* write port.

Verification (WORD_W=8, ADDR_W=8)
REQ-025 clear_en=1, len=5, words 00,50,03,40,80 -> 256 writes of 00 at 0..255, then writes 0->00, 1->50, 2->03, 3->40, 4->80; done pulse; cpu_rst=1; words_loaded=5.
REQ-026 clear_en=0, len=3, in_valid toggling every other cycle -> exactly 3 writes at 0..2 in order, no duplicates, in_ready=0 after third transfer.
REQ-027 len=257 -> err=1, no mem_we, busy=0, cpu_rst unchanged.
REQ-028 len=0, clear_en=0 -> no writes, done pulse within 2 cycles of start, cpu_rst=1.
REQ-029 abort after 2 of 4 words -> at most 2 writes (0,1), err=1, cpu_rst=0, IDLE; subsequent start with len=4 completes normally.
REQ-030 rst asserted mid-CLEAR at address 0x40 -> all outputs at reset values immediately, no further writes after rst release without a new start.
